// File: rtl/letter_renderer.sv
// Renders NUM_CH 8-bit letter bitmaps into a FB_W x FB_H framebuffer (clear, then OR-draw).
// Optional LETTER_RENDERER_DOUBLE_BUFFER_EN renders into a back buffer copied out on completion.
module letter_renderer #(
  parameter int unsigned FB_W     = 40,
  parameter int unsigned FB_H     = 30,
  parameter int unsigned NUM_CH   = 3,
  parameter int unsigned CELL_W   = 1,
  parameter int unsigned CELL_H   = 3,
  parameter int unsigned CH_PITCH = 13
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [8*NUM_CH-1:0]    letters,
  input  logic [5*NUM_CH-1:0]    ypos,
  output logic                   busy,
  output logic                   done,
  output logic [FB_W*FB_H-1:0]   framebuffer
);
  localparam int unsigned FBN = FB_W * FB_H;
  localparam int unsigned RW  = $clog2(FB_H) + 1;
  localparam int unsigned KW  = $clog2(CELL_H) + 1;
  localparam int unsigned CW  = $clog2(NUM_CH) + 1;
  // y and x carry a spare bit so clipped coordinates never alias onto visible pixels
  localparam int unsigned YW  = $clog2(32 + CELL_H) + 1;
  localparam int unsigned XW  = $clog2(FB_W + NUM_CH * CH_PITCH + 8 * CELL_W) + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CLEAR = 2'd1;
  localparam logic [1:0] DRAW  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [RW-1:0]       row_q, row_d;
  logic [CW-1:0]       ch_q, ch_d;
  logic [KW-1:0]       k_q, k_d;
  logic [8*NUM_CH-1:0] letters_q, letters_d;
  logic [5*NUM_CH-1:0] ypos_q, ypos_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [FBN-1:0]      wk_q, wk_d;
  logic [7:0]          cur_letter;
  logic [4:0]          cur_ypos;
  logic [YW-1:0]       draw_y;
  logic [XW-1:0]       base_x, px_x;
  logic [FB_W-1:0]     row_mask;

`ifdef LETTER_RENDERER_DOUBLE_BUFFER_EN
  logic [FBN-1:0]      fb_q, fb_d;
  assign framebuffer = fb_q;
`else
  assign framebuffer = wk_q;
`endif
  assign busy = busy_q;
  assign done = done_q;

  // Pixel mask for the current (channel, letter row) pair; out-of-range x never matches
  always_comb begin
    cur_letter = '0;
    cur_ypos   = '0;
    for (int c = 0; c < int'(NUM_CH); c++) begin
      if (ch_q == CW'(c)) begin
        cur_letter = letters_q[8*c +: 8];
        cur_ypos   = ypos_q[5*c +: 5];
      end
    end
    draw_y   = YW'(cur_ypos) + YW'(k_q);
    base_x   = XW'(ch_q) * XW'(CH_PITCH);
    px_x     = '0;
    row_mask = '0;
    for (int b = 0; b < 8; b++) begin
      for (int w = 0; w < int'(CELL_W); w++) begin
        px_x = base_x + XW'((7 - b) * int'(CELL_W) + w);
        for (int x = 0; x < int'(FB_W); x++) begin
          if (cur_letter[b] && (px_x == XW'(x))) row_mask[x] = 1'b1;
        end
      end
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    ch_d      = ch_q;
    k_d       = k_q;
    letters_d = letters_q;
    ypos_d    = ypos_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    wk_d      = wk_q;
`ifdef LETTER_RENDERER_DOUBLE_BUFFER_EN
    fb_d      = fb_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          letters_d = letters;
          ypos_d    = ypos;
          row_d     = '0;
          busy_d    = 1'b1;
          state_d   = CLEAR;
        end
      end
      CLEAR: begin
        for (int r = 0; r < int'(FB_H); r++) begin
          if (row_q == RW'(r)) wk_d[r*FB_W +: FB_W] = '0;
        end
        if (row_q == RW'(FB_H - 1)) begin
          ch_d    = '0;
          k_d     = '0;
          state_d = DRAW;
        end else begin
          row_d = row_q + RW'(1);
        end
      end
      DRAW: begin
        for (int r = 0; r < int'(FB_H); r++) begin
          if (draw_y == YW'(r)) wk_d[r*FB_W +: FB_W] = wk_q[r*FB_W +: FB_W] | row_mask;
        end
        if (k_q == KW'(CELL_H - 1)) begin
          k_d = '0;
          if (ch_q == CW'(NUM_CH - 1)) state_d = DONE;
          else                         ch_d    = ch_q + CW'(1);
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
`ifdef LETTER_RENDERER_DOUBLE_BUFFER_EN
        fb_d    = wk_q;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      row_q     <= '0;
      ch_q      <= '0;
      k_q       <= '0;
      letters_q <= '0;
      ypos_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wk_q      <= '0;
`ifdef LETTER_RENDERER_DOUBLE_BUFFER_EN
      fb_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      ch_q      <= ch_d;
      k_q       <= k_d;
      letters_q <= letters_d;
      ypos_q    <= ypos_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wk_q      <= wk_d;
`ifdef LETTER_RENDERER_DOUBLE_BUFFER_EN
      fb_q      <= fb_d;
`endif
    end
  end
endmodule

// File: tb/tb_letter_renderer.sv
// Directed self-checking bench for letter_renderer: default, 4-channel and overlapping/clipped configurations.
module tb_letter_renderer;
  localparam int W = 40;
  localparam int H = 30;
  localparam int W5 = 12;

  logic clock = 1'b0;
  logic reset;
  logic start, start4, start5;
  logic [23:0] letters;
  logic [14:0] ypos;
  logic busy, done;
  logic [W*H-1:0] fb;
  logic [31:0] letters4;
  logic [19:0] ypos4;
  logic busy4, done4;
  logic [W*H-1:0] fb4;
  logic [15:0] letters5;
  logic [9:0] ypos5;
  logic busy5, done5;
  logic [W5*H-1:0] fb5;

  logic [W*H-1:0] exp_fb, exp_a;
  logic [W5*H-1:0] exp5;
  int n_tests = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  letter_renderer dut (
    .clock(clock), .reset(reset), .start(start), .letters(letters), .ypos(ypos),
    .busy(busy), .done(done), .framebuffer(fb)
  );

  letter_renderer #(.NUM_CH(4), .CH_PITCH(10), .FB_W(40)) dut4 (
    .clock(clock), .reset(reset), .start(start4), .letters(letters4), .ypos(ypos4),
    .busy(busy4), .done(done4), .framebuffer(fb4)
  );

  letter_renderer #(.NUM_CH(2), .CH_PITCH(5), .FB_W(W5)) dut5 (
    .clock(clock), .reset(reset), .start(start5), .letters(letters5), .ypos(ypos5),
    .busy(busy5), .done(done5), .framebuffer(fb5)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic px(input int x, input int y);
    exp_fb[y*W+x] = 1'b1;
  endtask

  // Pulse start for one edge, then count edges until done (bounded)
  task automatic run_frame(output int n);
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b exp 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b exp 0", done); end
    n_tests++; if (fb !== '0) begin n_fail++; $display("FAIL reset_fb: got %h exp 0", fb); end
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int n;
    letters = {8'h03, 8'h02, 8'h01};
    ypos    = {5'd21, 5'd10, 5'd0};
    exp_fb = '0;
    for (int y = 0; y < 3; y++) begin
      px(7, y); px(19, 10 + y); px(32, 21 + y); px(33, 21 + y);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_rise: got %b exp 1", busy); end
    n = 0;
    while (!done && n < 200) begin tick(); n++; end
    n_tests++; if (n !== 40) begin n_fail++; $display("FAIL basic_latency: got %0d exp 40", n); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_at_done: got %b exp 0", busy); end
    n_tests++; if (fb !== exp_fb) begin n_fail++; $display("FAIL basic_frame: got %h exp %h", fb, exp_fb); end
    tick();
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_width: got %b exp 0", done); end
  endtask

  task automatic test_clip();
    int n;
    letters = {8'h00, 8'hFF, 8'hFF};
    ypos    = {5'd0, 5'd30, 5'd28};
    exp_fb = '0;
    for (int x = 0; x < 8; x++) begin px(x, 28); px(x, 29); end
    run_frame(n);
    n_tests++; if (n !== 40) begin n_fail++; $display("FAIL clip_latency: got %0d exp 40", n); end
    n_tests++; if (fb !== exp_fb) begin n_fail++; $display("FAIL clip_frame: got %h exp %h", fb, exp_fb); end
    tick();
  endtask

  task automatic test_back_to_back();
    int n;
    letters = {8'h00, 8'h00, 8'h80};
    ypos    = {5'd0, 5'd0, 5'd5};
    start = 1'b1;
    tick();
    letters = {8'h00, 8'h00, 8'h01};
    n = 0;
    while (!done && n < 200) begin tick(); n++; end
    n_tests++; if (n !== 40) begin n_fail++; $display("FAIL b2b_first_latency: got %0d exp 40", n); end
    exp_fb = '0;
    for (int y = 5; y < 8; y++) px(0, y);
    n_tests++; if (fb !== exp_fb) begin n_fail++; $display("FAIL b2b_first_frame: got %h exp %h", fb, exp_fb); end
    tick();
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL b2b_done_width: got %b exp 0", done); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_restart_busy: got %b exp 1", busy); end
    n = 0;
    while (!done && n < 200) begin tick(); n++; end
    n_tests++; if (n !== 40) begin n_fail++; $display("FAIL b2b_period: got %0d exp 40 after restart edge", n); end
    exp_fb = '0;
    for (int y = 5; y < 8; y++) px(7, y);
    n_tests++; if (fb !== exp_fb) begin n_fail++; $display("FAIL b2b_second_frame: got %h exp %h", fb, exp_fb); end
    start = 1'b0;
    tick();
  endtask

  task automatic test_start_in_done();
    letters = {8'h00, 8'h00, 8'h01};
    ypos    = 15'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 39; i++) tick();
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL sid_done_early: got %b exp 0", done); end
    start = 1'b1;
    tick();
    n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL sid_done: got %b exp 1", done); end
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL sid_ignored: busy got %b exp 0", busy); end
  endtask

  task automatic test_reset_mid();
    int n;
    int ndone;
    letters = {8'h03, 8'h02, 8'h01};
    ypos    = {5'd21, 5'd10, 5'd0};
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    reset = 1'b1;
    #1;
    n_tests++; if (fb !== '0) begin n_fail++; $display("FAIL rmid_fb: got %h exp 0", fb); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b exp 0", busy); end
    tick();
    reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 60; i++) begin tick(); if (done) ndone++; end
    n_tests++; if (ndone !== 0) begin n_fail++; $display("FAIL rmid_no_done: got %0d pulses exp 0", ndone); end
    letters = {8'h00, 8'h00, 8'hFF};
    ypos    = 15'd0;
    exp_fb = '0;
    for (int y = 0; y < 3; y++) for (int x = 0; x < 8; x++) px(x, y);
    run_frame(n);
    n_tests++; if (n !== 40) begin n_fail++; $display("FAIL rmid_latency: got %0d exp 40", n); end
    n_tests++; if (fb !== exp_fb) begin n_fail++; $display("FAIL rmid_frame: got %h exp %h", fb, exp_fb); end
    tick();
  endtask

  task automatic test_buffering();
    int n;
    int bad;
    letters = {8'h03, 8'h02, 8'h01};
    ypos    = {5'd21, 5'd10, 5'd0};
    exp_fb = '0;
    for (int y = 0; y < 3; y++) begin
      px(7, y); px(19, 10 + y); px(32, 21 + y); px(33, 21 + y);
    end
    exp_a = exp_fb;
    run_frame(n);
    tick();
    letters = {8'h00, 8'hFF, 8'hFF};
    ypos    = {5'd0, 5'd30, 5'd28};
    exp_fb = '0;
    for (int x = 0; x < 8; x++) begin px(x, 28); px(x, 29); end
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    bad = 0;
    while (!done && n < 200) begin
`ifdef LETTER_RENDERER_DOUBLE_BUFFER_EN
      if (fb !== exp_a) bad++;
`else
      if (n == 30 && fb !== '0) bad++;
`endif
      tick();
      n++;
    end
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL buf_during_busy: got %0d bad cycles exp 0", bad); end
    n_tests++; if (fb !== exp_fb) begin n_fail++; $display("FAIL buf_final: got %h exp %h", fb, exp_fb); end
    tick();
  endtask

  task automatic test_num_ch4();
    int n;
    letters4 = {8'h80, 24'h0};
    ypos4    = 20'd0;
    exp_fb = '0;
    for (int y = 0; y < 3; y++) px(30, y);
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    n = 0;
    while (!done4 && n < 200) begin tick(); n++; end
    n_tests++; if (n !== 43) begin n_fail++; $display("FAIL ch4_latency: got %0d exp 43", n); end
    n_tests++; if (fb4 !== exp_fb) begin n_fail++; $display("FAIL ch4_frame: got %h exp %h", fb4, exp_fb); end
    tick();
  endtask

  task automatic test_overlap();
    int n;
    letters5 = {8'h1F, 8'hFF};
    ypos5    = 10'd0;
    exp5 = '0;
    for (int y = 0; y < 3; y++) for (int x = 0; x < W5; x++) exp5[y*W5+x] = 1'b1;
    start5 = 1'b1;
    tick();
    start5 = 1'b0;
    n = 0;
    while (!done5 && n < 200) begin tick(); n++; end
    n_tests++; if (n !== 37) begin n_fail++; $display("FAIL ovl_latency: got %0d exp 37", n); end
    n_tests++; if (fb5 !== exp5) begin n_fail++; $display("FAIL ovl_frame: got %h exp %h", fb5, exp5); end
    tick();
  endtask

  initial begin
    start = 1'b0; start4 = 1'b0; start5 = 1'b0;
    letters = '0; ypos = '0;
    letters4 = '0; ypos4 = '0;
    letters5 = '0; ypos5 = '0;
    test_reset();
    test_basic();
    test_clip();
    test_back_to_back();
    test_start_in_done();
    test_reset_mid();
    test_buffering();
    test_num_ch4();
    test_overlap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
